// File: rtl/add_seq32_pkg.sv
// rtl/add_seq32_pkg.sv - state type and slice constants for add_seq32
`include "add_seq_defs.v"

package add_seq32_pkg;

    localparam int SLICE = `ADD_SEQ_SLICE;

    typedef enum logic [1:0] {
        ST_IDLE = `ADD_SEQ_IDLE,
        ST_RUN  = `ADD_SEQ_RUN,
        ST_DONE = `ADD_SEQ_DONE
    } state_t;

endpackage

// File: rtl/add_seq32_full_add8.sv
// rtl/add_seq32_full_add8.sv - 8-bit full-adder slice shared across all byte steps
module full_add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    end

endmodule

// File: rtl/add_seq_defs.v
// rtl/add_seq_defs.v - shared state encodings and slice width for the byte-serial adder
`ifndef ADD_SEQ_DEFS_V
`define ADD_SEQ_DEFS_V
`define ADD_SEQ_IDLE  2'd0
`define ADD_SEQ_RUN   2'd1
`define ADD_SEQ_DONE  2'd2
`define ADD_SEQ_SLICE 8
`endif

// File: rtl/add_seq32.sv
// rtl/add_seq32.sv - multi-cycle byte-serial add/subtract unit with valid/ready handshakes
module add_seq32
    import add_seq32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             oflow,
    output logic             sign
);

    localparam int N      = WIDTH / SLICE;
    localparam int STEP_W = $clog2(N);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

    state_t            state;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic              carry;
    logic              a_msb;
    logic              bx_msb;
    logic [7:0]        sum8;
    logic              cout8;
    logic              oflow_next;

    full_add8 u_slice (
        .a    (a_sh[7:0]),
        .b    (b_sh[7:0]),
        .cin  (carry),
        .sum  (sum8),
        .cout (cout8)
    );

    // Overflow only matters on the MSB slice; sum8[7] is the result sign bit there.
    assign oflow_next = (a_msb == bx_msb) & (sum8[7] != a_msb);
    assign in_ready   = (state == ST_IDLE) & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            step      <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            a_msb     <= 1'b0;
            bx_msb    <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            oflow     <= 1'b0;
            sign      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b ^ {WIDTH{sub}};
                        carry  <= sub | cin;
                        a_msb  <= a[WIDTH-1];
                        bx_msb <= b[WIDTH-1] ^ sub;
                        step   <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> SLICE;
                    b_sh  <= b_sh >> SLICE;
                    s     <= {sum8, s[WIDTH-1:SLICE]};
                    carry <= cout8;
                    step  <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        cout      <= cout8;
                        oflow     <= oflow_next;
                        sign      <= oflow_next ? ~sum8[7] : sum8[7];
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
